// File: rtl/tap_tempo_detector.sv
// Tap-tempo detector: debounces a tap key, averages the last up to four tap
// intervals and reports the tempo in BPM as binary and as three BCD digits.
module tap_tempo_detector #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned TIMEOUT_CYC  = 150000000,
    parameter int unsigned BPM_MIN      = 30,
    parameter int unsigned BPM_MAX      = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tap_n,
    output logic [7:0] bpm,
    output logic [3:0] hex0,
    output logic [3:0] hex10,
    output logic [3:0] hex100,
    output logic       bpm_valid,
    output logic       active
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC);
    localparam logic [33:0] ONE_MIN = 34'(64'(CLK_HZ) * 64'd60);

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        LOAD,
        DIVIDE,
        CLAMP,
        BCD,
        EMIT
    } state_t;

    state_t state, state_nx;

    logic            sync1, sync2;
    logic            armed;
    logic [DB_W-1:0] db_cnt;
    logic            tap_evt;

    logic [27:0]       period;
    logic [27:0]       ival;
    logic [3:0][27:0]  hist;
    logic [29:0]       sum;
    logic [2:0]        n;
    logic              record, drop;

    logic [33:0] dq;
    logic [29:0] rem;
    logic [30:0] trial;
    logic        fits;
    logic [5:0]  iter;
    logic [7:0]  clamp_b, b_reg;
    logic [19:0] dd, dd_adj, dd_next;

    assign tap_evt = armed & ~sync2;

    // Synchronizer and re-arm debouncer; any low sample restarts the release count.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            armed  <= 1'b1;
            db_cnt <= '0;
        end else begin
            sync1 <= tap_n;
            sync2 <= sync1;
            if (tap_evt) begin
                armed  <= 1'b0;
                db_cnt <= '0;
            end else if (!armed) begin
                if (!sync2) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                    armed  <= 1'b1;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            period <= '0;
        end else if (tap_evt) begin
            period <= '0;
        end else if (period != '1) begin
            period <= period + 28'd1;
        end
    end

    // The counter is cleared in the tap cycle, so it lags the interval by one.
    assign ival = (period == '1) ? period : period + 28'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        record    = 1'b0;
        drop      = 1'b0;
        active    = (state != IDLE);
        bpm_valid = (state == EMIT);
        case (state)
            IDLE: begin
                if (tap_evt) state_nx = MEASURE;
            end
            MEASURE: begin
                if (tap_evt) begin
                    record   = 1'b1;
                    state_nx = LOAD;
                end else if (period >= 28'(TIMEOUT_CYC)) begin
                    drop     = 1'b1;
                    state_nx = IDLE;
                end
            end
            LOAD:    state_nx = DIVIDE;
            DIVIDE: begin
                if (iter == 6'd33) state_nx = CLAMP;
            end
            CLAMP:   state_nx = BCD;
            BCD: begin
                if (iter == 6'd7) state_nx = EMIT;
            end
            EMIT:    state_nx = MEASURE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        trial = {rem, dq[33]};
        fits  = (trial >= {1'b0, sum});

        clamp_b = dq[7:0];
        if (dq < 34'(BPM_MIN)) begin
            clamp_b = 8'(BPM_MIN);
        end else if (dq > 34'(BPM_MAX)) begin
            clamp_b = 8'(BPM_MAX);
        end

        dd_adj = dd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (dd_adj[8 + 4*i +: 4] >= 4'd5) begin
                dd_adj[8 + 4*i +: 4] = dd_adj[8 + 4*i +: 4] + 4'd3;
            end
        end
        dd_next = {dd_adj[18:0], 1'b0};
    end

    // dq holds the dividend bits still to be consumed and collects quotient bits behind them.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist   <= '0;
            sum    <= '0;
            n      <= '0;
            dq     <= '0;
            rem    <= '0;
            iter   <= '0;
            b_reg  <= '0;
            dd     <= '0;
            bpm    <= '0;
            hex0   <= '0;
            hex10  <= '0;
            hex100 <= '0;
        end else begin
            if (drop) begin
                hist <= '0;
                sum  <= '0;
                n    <= '0;
            end else if (record) begin
                hist <= {hist[2:0], ival};
                sum  <= sum + 30'(ival) - ((n == 3'd4) ? 30'(hist[3]) : 30'd0);
                n    <= (n == 3'd4) ? 3'd4 : n + 3'd1;
            end

            case (state)
                LOAD: begin
                    dq   <= 34'(ONE_MIN * 34'(n));
                    rem  <= '0;
                    iter <= '0;
                end
                DIVIDE: begin
                    if (fits) begin
                        rem <= 30'(trial - {1'b0, sum});
                        dq  <= {dq[32:0], 1'b1};
                    end else begin
                        rem <= trial[29:0];
                        dq  <= {dq[32:0], 1'b0};
                    end
                    iter <= iter + 6'd1;
                end
                CLAMP: begin
                    b_reg <= clamp_b;
                    dd    <= {12'd0, clamp_b};
                    iter  <= '0;
                end
                BCD: begin
                    dd   <= dd_next;
                    iter <= iter + 6'd1;
                    if (iter == 6'd7) begin
                        bpm    <= b_reg;
                        hex100 <= dd_next[19:16];
                        hex10  <= dd_next[15:12];
                        hex0   <= dd_next[11:8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
